// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with an in-order prefetch queue.
// Issues word fetches ahead of the decoder over a request/grant memory port, buffers the
// in-order responses in a DEPTH-entry queue and presents them with a valid/ready handshake.
// A redirect flushes the queue and discards responses still in flight.
// Optional macro IFU_PREFETCH_PERF_EN adds the perf_fetched / perf_discarded counters.

`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module ifu_prefetch #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter int unsigned     MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
`ifdef IFU_PREFETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_discarded
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  // Address of the next response that will be kept (not discarded).
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] discard_q, discard_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];

  logic [CntW:0]   credit_used;
  logic            handshake;
  logic            drop;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_tgt;

  assign credit_used  = {1'b0, count_q} + {1'b0, outst_q};
  assign redirect_tgt = redirect_pc & ~XLEN'(3);

  // Credits cover queue space for every outstanding request, so a response is never refused.
  assign mem_req = rst_n & ~redirect & (credit_used < (CntW + 1)'(DEPTH))
                 & (outst_q < CntW'(MAX_OUTST));
  assign mem_addr  = fetch_pc_q;
  assign handshake = mem_req & mem_gnt;

  // A response arriving in a redirect cycle belongs to the old stream as well.
  assign drop = mem_rvalid & (redirect | (discard_q != '0));
  assign push = mem_rvalid & ~drop;

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid & inst_ready;
  assign inst       = inst_valid ? data_mem_q[rd_ptr_q] : XLEN'(`INST_NOP);
  assign inst_pc    = inst_valid ? pc_mem_q[rd_ptr_q] : '0;

  // Next-state for fetch PC, credit counters and queue pointers.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q + CntW'(handshake) - CntW'(mem_rvalid);
    discard_d  = discard_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect) begin
      fetch_pc_d = redirect_tgt;
      resp_pc_d  = redirect_tgt;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // Everything still in flight belongs to the abandoned stream.
      discard_d  = outst_q - CntW'(mem_rvalid);
    end else begin
      if (handshake) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push)      resp_pc_d  = resp_pc_q + XLEN'(4);
      if (mem_rvalid && (discard_q != '0)) discard_d = discard_q - CntW'(1);
      count_d  = count_q + CntW'(push) - CntW'(pop);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      wr_ptr_d = wr_ptr_q + PtrW'(push);
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Queue storage; contents are qualified by count_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
      data_mem_q[wr_ptr_q] <= mem_rdata;
    end
  end

`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0]     perf_fetched_q, perf_fetched_d;
  logic [31:0]     perf_discarded_q, perf_discarded_d;
  logic [CntW-1:0] flushed;
  logic [32:0]     fetched_sum;
  logic [32:0]     discarded_sum;

  // A pop in the redirect cycle still completes, so it is not counted as flushed.
  assign flushed       = redirect ? (count_q - CntW'(pop)) : '0;
  assign fetched_sum   = {1'b0, perf_fetched_q} + 33'(pop);
  assign discarded_sum = {1'b0, perf_discarded_q} + 33'(flushed) + 33'(drop);

  // Saturating event counters.
  always_comb begin
    perf_fetched_d   = fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
    perf_discarded_d = discarded_sum[32] ? 32'hFFFF_FFFF : discarded_sum[31:0];
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q   <= '0;
      perf_discarded_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_discarded_q <= perf_discarded_d;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_discarded = perf_discarded_q;
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding means the memory side lost track of requests.
  rvalid_has_outst_a: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rvalid |-> (outst_q != '0));
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed self-checking bench for ifu_prefetch with a small in-order memory model.

`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module tb_ifu_prefetch;

  localparam logic [31:0] RstPc = 32'h0000_0100;
  localparam logic [31:0] Nop   = `INST_NOP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_discarded;
`endif

  always #5 clk = ~clk;

  ifu_prefetch #(
    .XLEN      (32),
    .DEPTH     (4),
    .MAX_OUTST (2),
    .RESET_PC  (RstPc)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
`ifdef IFU_PREFETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_discarded (perf_discarded)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t pend[$];
  int   cycle    = 0;
  int   lat      = 1;
  int   hs_total = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // One clock: record the handshake of the ending cycle, then drive the memory response
  // for the new cycle. Data returned is the bitwise inverse of the word address.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    #1;
    hs = mem_req && mem_gnt;
    a  = mem_addr;
    @(posedge clk);
    #1;
    cycle++;
    if (!rst_n) begin
      pend.delete();
    end else if (hs) begin
      pend.push_back('{addr: a, due: cycle - 1 + lat});
      hs_total++;
    end
    if (pend.size() > 0 && pend[0].due <= cycle) begin
      mem_rvalid = 1'b1;
      mem_rdata  = ~pend[0].addr;
      void'(pend.pop_front());
    end else begin
      mem_rvalid = 1'b0;
    end
    #1;
  endtask

  // Leaves the bench in the first cycle with rst_n released and all state at reset values.
  task automatic reset_dut();
    rst_n    = 1'b0;
    redirect = 1'b0;
    mem_gnt  = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [31:0] hs0;

    // Reset state and zero-wait streaming.
    lat        = 1;
    inst_ready = 1'b1;
    rst_n      = 1'b0;
    tick();
    tick();
    check_eq("rst_valid", inst_valid, 1'b0);
    check_eq("rst_inst", inst, Nop);
    check_eq("rst_pc", inst_pc, 32'h0);
    check_eq("rst_req", mem_req, 1'b0);
    check_eq("rst_addr", mem_addr, RstPc);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 7; k++) begin
      check_eq("stream_addr", mem_addr, RstPc + 32'(4 * k));
      if (k >= 2) begin
        check_eq("stream_valid", inst_valid, 1'b1);
        check_eq("stream_pc", inst_pc, RstPc + 32'(4 * (k - 2)));
        check_eq("stream_inst", inst, ~(RstPc + 32'(4 * (k - 2))));
      end else begin
        check_eq("stream_idle", inst_valid, 1'b0);
      end
      tick();
    end

    // Back-pressure fills the queue with exactly DEPTH fetches, then drains in order.
    inst_ready = 1'b0;
    reset_dut();
    hs0 = 32'(hs_total);
    repeat (10) tick();
    check_eq("bp_handshakes", 32'(hs_total) - hs0, 32'd4);
    check_eq("bp_req", mem_req, 1'b0);
    check_eq("bp_valid", inst_valid, 1'b1);
    check_eq("bp_pc", inst_pc, RstPc);
    inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq("drain_pc", inst_pc, RstPc + 32'(4 * k));
      check_eq("drain_valid", inst_valid, 1'b1);
      tick();
    end

    // Slow memory: redirect with two requests outstanding drops both stale responses.
    lat        = 3;
    inst_ready = 1'b1;
    reset_dut();
    tick();
    tick();
    check_eq("outst_cap", mem_req, 1'b0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2002;
    #1;
    check_eq("redir_req", mem_req, 1'b0);
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 15 && !inst_valid; i++) begin
      check_eq("gap_inst", inst, Nop);
      check_eq("gap_pc", inst_pc, 32'h0);
      tick();
    end
    check_eq("redir_first_pc", inst_pc, 32'h0000_2000);
    check_eq("redir_first_inst", inst, ~32'h0000_2000);

    // Redirect held three cycles: only the last target is fetched.
    lat = 1;
    reset_dut();
    repeat (6) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_pc = 32'h80;
    check_eq("hold_valid1", inst_valid, 1'b0);
    tick();
    redirect_pc = 32'hC0;
    check_eq("hold_valid2", inst_valid, 1'b0);
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 10 && !inst_valid; i++) tick();
    for (int k = 0; k < 4; k++) begin
      check_eq("hold_pc", inst_pc, 32'hC0 + 32'(4 * k));
      check_eq("hold_inst", inst, ~(32'hC0 + 32'(4 * k)));
      tick();
    end

    // Address wrap, then reset while the queue is full.
    reset_dut();
    repeat (3) tick();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check_eq("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    tick();
    check_eq("wrap_addr1", mem_addr, 32'h0);
    tick();
    check_eq("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
    tick();
    check_eq("wrap_pc1", inst_pc, 32'h0);
    inst_ready = 1'b0;
    repeat (8) tick();
    check_eq("full_valid", inst_valid, 1'b1);
    check_eq("full_req", mem_req, 1'b0);
    rst_n = 1'b0;
    tick();
    check_eq("midrst_valid", inst_valid, 1'b0);
    check_eq("midrst_req", mem_req, 1'b0);
    check_eq("midrst_addr", mem_addr, RstPc);
    check_eq("midrst_inst", inst, Nop);

`ifdef IFU_PREFETCH_PERF_EN
    // Five pops, then a redirect with two queued entries and one request in flight.
    lat        = 1;
    inst_ready = 1'b1;
    reset_dut();
    repeat (6) tick();
    tick();
    inst_ready = 1'b0;
    lat        = 4;
    tick();
    check_eq("perf_fetched_pre", perf_fetched, 32'd5);
    check_eq("perf_queued", inst_valid, 1'b1);
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    mem_gnt  = 1'b0;
    check_eq("perf_disc_flush", perf_discarded, 32'd2);
    repeat (4) tick();
    check_eq("perf_fetched", perf_fetched, 32'd5);
    check_eq("perf_discarded", perf_discarded, 32'd3);
    mem_gnt = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d cycles expected fewer", cycle);
    $fatal(1);
  end

endmodule
